// File: rtl/clock_pkg.sv
// Shared definitions for the adv_clock time-of-day block: mode encoding,
// field widths and the 11<->12 crossing test used for the AM/PM flag.
package clock_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef enum logic [1:0] {
    MODE_COUNT     = 2'd0,
    MODE_SET_MIN   = 2'd1,
    MODE_SET_HOUR  = 2'd2,
    MODE_CLEAR_SEC = 2'd3
  } mode_e;

  // True when a step of the hours field crosses between 11 and 12, which is
  // where the 12-hour AM/PM flag flips.
  function automatic logic crosses_noon(input logic up, input logic [HOUR_W-1:0] hours);
    return up ? (hours == HOUR_W'(11)) : (hours == HOUR_W'(12));
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Bounded up/down counter with wrap-around, used for every time field.
// carry flags the cycle in which an enabled step wraps past the bound.
module wrap_counter #(
  parameter int MIN   = 0,
  parameter int MAX   = 59,
  parameter int WIDTH = 6,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // NOTE: value_d takes its hold value first so every path assigns it and no
  // latch is inferred.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = MIN_V;
    end else if (en) begin
      if (up) value_d = (value_q == MAX_V) ? MIN_V : value_q + 1'b1;
      else    value_d = (value_q == MIN_V) ? MAX_V : value_q - 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // their inputs from the same clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= INIT_V;
    else        value_q <= value_d;
  end

  assign value = value_q;
  assign carry = en & ~clr & (up ? (value_q == MAX_V) : (value_q == MIN_V));

endmodule

// File: rtl/adv_clock.sv
// Time-of-day clock with count/set/clear modes, 24h or 12h+AM/PM format.
// Define ADV_CLOCK_ALARM_EN to add an editable alarm and its match pulse.
module adv_clock
  import clock_pkg::*;
#(
  parameter int HOURS_24     = 1,
  parameter int INIT_HOURS   = 12,
  parameter int INIT_MINUTES = 0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_1hz_stb,
  input  logic              i_timeset_stb,
  input  logic [1:0]        i_mode,
  input  logic              i_set_down,
  output logic              o_clk_stb,
  output logic [SEC_W-1:0]  o_seconds,
  output logic [MIN_W-1:0]  o_minutes,
  output logic [HOUR_W-1:0] o_hours,
  output logic              o_pm,
  output logic              o_day_stb
`ifdef ADV_CLOCK_ALARM_EN
  ,
  input  logic              i_alarm_sel,
  input  logic              i_alarm_en,
  output logic [MIN_W-1:0]  o_alarm_minutes,
  output logic [HOUR_W-1:0] o_alarm_hours,
  output logic              o_alarm_pm,
  output logic              o_alarm
`endif
);

  localparam bit IS_24  = (HOURS_24 != 0);
  localparam int HR_MIN = IS_24 ? 0 : 1;
  localparam int HR_MAX = IS_24 ? 23 : 12;
  localparam logic [HOUR_W-1:0] HR_11 = HOUR_W'(11);

  if (INIT_MINUTES < 0 || INIT_MINUTES > 59) begin : g_bad_init_minutes
    $error("adv_clock: INIT_MINUTES out of range 0..59");
  end
  if (INIT_HOURS < HR_MIN || INIT_HOURS > HR_MAX) begin : g_bad_init_hours
    $error("adv_clock: INIT_HOURS out of range for the selected hour format");
  end

  mode_e mode;
  logic  edit_alarm;
  logic  count_upd;
  logic  step_up;
  logic  sec_en, sec_clr, sec_carry;
  logic  min_en, min_carry;
  logic  hr_en, hr_carry;
  logic  pm_q, pm_d;
  logic  day_q, day_d;

  assign mode      = mode_e'(i_mode);
  assign o_clk_stb = (mode != MODE_COUNT) ? i_timeset_stb : i_1hz_stb;

`ifdef ADV_CLOCK_ALARM_EN
  assign edit_alarm = i_alarm_sel;
`else
  assign edit_alarm = 1'b0;
`endif

  // Counting always steps upwards; the set modes follow i_set_down.
  assign count_upd = o_clk_stb & (mode == MODE_COUNT);
  assign step_up   = (mode == MODE_COUNT) | ~i_set_down;

  assign sec_en  = count_upd;
  assign sec_clr = o_clk_stb & (mode == MODE_CLEAR_SEC);
  assign min_en  = (count_upd & sec_carry)
                 | (o_clk_stb & (mode == MODE_SET_MIN) & ~edit_alarm);
  assign hr_en   = (count_upd & min_carry)
                 | (o_clk_stb & (mode == MODE_SET_HOUR) & ~edit_alarm);

  wrap_counter #(.MIN(0), .MAX(59), .WIDTH(SEC_W), .INIT(0)) u_seconds (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (sec_en),
    .up    (1'b1),
    .clr   (sec_clr),
    .value (o_seconds),
    .carry (sec_carry)
  );

  wrap_counter #(.MIN(0), .MAX(59), .WIDTH(MIN_W), .INIT(INIT_MINUTES)) u_minutes (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (min_en),
    .up    (step_up),
    .clr   (1'b0),
    .value (o_minutes),
    .carry (min_carry)
  );

  wrap_counter #(.MIN(HR_MIN), .MAX(HR_MAX), .WIDTH(HOUR_W), .INIT(INIT_HOURS)) u_hours (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (hr_en),
    .up    (step_up),
    .clr   (1'b0),
    .value (o_hours),
    .carry (hr_carry)
  );

  // The day ends on 23->0 in 24h format, or 11 PM -> 12 AM in 12h format.
  always_comb begin
    pm_d = pm_q;
    if (!IS_24 && hr_en && crosses_noon(step_up, o_hours)) pm_d = ~pm_q;
    day_d = count_upd & (IS_24 ? hr_carry : (hr_en & (o_hours == HR_11) & pm_q));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pm_q  <= 1'b0;
      day_q <= 1'b0;
    end else begin
      pm_q  <= pm_d;
      day_q <= day_d;
    end
  end

  assign o_pm      = pm_q;
  assign o_day_stb = day_q;

`ifdef ADV_CLOCK_ALARM_EN
  logic amin_en, ahr_en;
  logic amin_carry_unused, ahr_carry_unused;
  logic apm_q, apm_d;
  logic arm_q, arm_d;

  assign amin_en = o_clk_stb & (mode == MODE_SET_MIN)  & edit_alarm;
  assign ahr_en  = o_clk_stb & (mode == MODE_SET_HOUR) & edit_alarm;

  wrap_counter #(.MIN(0), .MAX(59), .WIDTH(MIN_W), .INIT(0)) u_alarm_minutes (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (amin_en),
    .up    (~i_set_down),
    .clr   (1'b0),
    .value (o_alarm_minutes),
    .carry (amin_carry_unused)
  );

  wrap_counter #(.MIN(HR_MIN), .MAX(HR_MAX), .WIDTH(HOUR_W), .INIT(IS_24 ? 0 : 12)) u_alarm_hours (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (ahr_en),
    .up    (~i_set_down),
    .clr   (1'b0),
    .value (o_alarm_hours),
    .carry (ahr_carry_unused)
  );

  // arm_q marks the cycle right after a counting update rolled seconds to 0;
  // the alarm registers cannot change then, so the match is stable.
  always_comb begin
    apm_d = apm_q;
    if (!IS_24 && ahr_en && crosses_noon(~i_set_down, o_alarm_hours)) apm_d = ~apm_q;
    arm_d = count_upd & sec_carry & i_alarm_en;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      apm_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      apm_q <= apm_d;
      arm_q <= arm_d;
    end
  end

  assign o_alarm_pm = apm_q;
  assign o_alarm    = arm_q & (o_minutes == o_alarm_minutes)
                    & (o_hours == o_alarm_hours) & (o_pm == apm_q);
`endif

endmodule

// File: tb/tb_adv_clock.sv
// Self-checking bench for adv_clock: a 24h instance driven from a vector
// table plus hand sequences, and a 12h instance for AM/PM corner cases.
module tb_adv_clock;
  import clock_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stb_1hz, stb_ts, set_down;
  logic [1:0] mode;

  logic       cs24, pm24, day24, cs12, pm12, day12;
  logic [5:0] s24, m24, s12, m12;
  logic [4:0] h24, h12;

`ifdef ADV_CLOCK_ALARM_EN
  logic       alarm_sel, alarm_en;
  logic [5:0] am24, am12;
  logic [4:0] ah24, ah12;
  logic       apm24, apm12, al24, al12;
`endif

  int checks = 0;
  int errors = 0;
  int day24_seen, day12_seen, alarm_cnt;

  always #5 clk = ~clk;

  adv_clock dut24 (
    .i_clk(clk), .i_reset_n(rst_n), .i_1hz_stb(stb_1hz), .i_timeset_stb(stb_ts),
    .i_mode(mode), .i_set_down(set_down), .o_clk_stb(cs24), .o_seconds(s24),
    .o_minutes(m24), .o_hours(h24), .o_pm(pm24), .o_day_stb(day24)
`ifdef ADV_CLOCK_ALARM_EN
    , .i_alarm_sel(alarm_sel), .i_alarm_en(alarm_en), .o_alarm_minutes(am24),
    .o_alarm_hours(ah24), .o_alarm_pm(apm24), .o_alarm(al24)
`endif
  );

  adv_clock #(.HOURS_24(0), .INIT_HOURS(11), .INIT_MINUTES(59)) dut12 (
    .i_clk(clk), .i_reset_n(rst_n), .i_1hz_stb(stb_1hz), .i_timeset_stb(stb_ts),
    .i_mode(mode), .i_set_down(set_down), .o_clk_stb(cs12), .o_seconds(s12),
    .o_minutes(m12), .o_hours(h12), .o_pm(pm12), .o_day_stb(day12)
`ifdef ADV_CLOCK_ALARM_EN
    , .i_alarm_sel(alarm_sel), .i_alarm_en(alarm_en), .o_alarm_minutes(am12),
    .o_alarm_hours(ah12), .o_alarm_pm(apm12), .o_alarm(al12)
`endif
  );

  typedef struct {
    logic [1:0] mode;
    logic       dn;
    logic       hz;
    logic       ts;
    int         h;
    int         m;
    int         s;
    int         day;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk24(input string tag, input int h, input int m, input int s, input int day);
    check({tag, ".hours"}, 32'(h24), h);
    check({tag, ".minutes"}, 32'(m24), m);
    check({tag, ".seconds"}, 32'(s24), s);
    check({tag, ".day_stb"}, 32'(day24), day);
  endtask

  task automatic chk12(input string tag, input int h, input int m, input int s, input int pm, input int day);
    check({tag, ".hours12"}, 32'(h12), h);
    check({tag, ".minutes12"}, 32'(m12), m);
    check({tag, ".seconds12"}, 32'(s12), s);
    check({tag, ".pm12"}, 32'(pm12), pm);
    check({tag, ".day_stb12"}, 32'(day12), day);
  endtask

  // Called at a negedge: drives one cycle of inputs, returns at the next negedge.
  task automatic tick(input logic [1:0] m, input logic dn, input logic hz, input logic ts);
    mode = m; set_down = dn; stb_1hz = hz; stb_ts = ts;
    @(negedge clk);
    stb_1hz = 1'b0; stb_ts = 1'b0;
    day24_seen += int'(day24);
    day12_seen += int'(day12);
`ifdef ADV_CLOCK_ALARM_EN
    alarm_cnt += int'(al24);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    day24_seen = 0; day12_seen = 0; alarm_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0; stb_1hz = 1'b0; stb_ts = 1'b0; set_down = 1'b0; mode = MODE_COUNT;
`ifdef ADV_CLOCK_ALARM_EN
    alarm_sel = 1'b0; alarm_en = 1'b0;
`endif
    day24_seen = 0; day12_seen = 0; alarm_cnt = 0;

    vq.push_back('{MODE_COUNT,     1'b0, 1'b1, 1'b0, 12,  0, 1, 0});
    vq.push_back('{MODE_COUNT,     1'b0, 1'b1, 1'b0, 12,  0, 2, 0});
    vq.push_back('{MODE_COUNT,     1'b0, 1'b1, 1'b0, 12,  0, 3, 0});
    vq.push_back('{MODE_COUNT,     1'b0, 1'b0, 1'b1, 12,  0, 3, 0});
    vq.push_back('{MODE_SET_MIN,   1'b1, 1'b0, 1'b1, 12, 59, 3, 0});
    vq.push_back('{MODE_SET_MIN,   1'b1, 1'b1, 1'b0, 12, 59, 3, 0});
    vq.push_back('{MODE_SET_MIN,   1'b0, 1'b0, 1'b1, 12,  0, 3, 0});
    vq.push_back('{MODE_SET_HOUR,  1'b0, 1'b0, 1'b1, 13,  0, 3, 0});
    vq.push_back('{MODE_SET_HOUR,  1'b1, 1'b0, 1'b1, 12,  0, 3, 0});
    vq.push_back('{MODE_CLEAR_SEC, 1'b0, 1'b0, 1'b1, 12,  0, 0, 0});
    vq.push_back('{MODE_CLEAR_SEC, 1'b0, 1'b1, 1'b0, 12,  0, 0, 0});
    vq.push_back('{MODE_COUNT,     1'b0, 1'b1, 1'b0, 12,  0, 1, 0});
    for (int hh = 11; hh >= 5; hh--)
      vq.push_back('{MODE_SET_HOUR, 1'b1, 1'b0, 1'b1, hh, 0, 1, 0});
    vq.push_back('{MODE_SET_MIN,   1'b1, 1'b0, 1'b1,  5, 59, 1, 0});
    vq.push_back('{MODE_SET_MIN,   1'b1, 1'b1, 1'b0,  5, 59, 1, 0});
    vq.push_back('{MODE_COUNT,     1'b0, 1'b0, 1'b0,  5, 59, 1, 0});
    vq.push_back('{MODE_COUNT,     1'b0, 1'b1, 1'b0,  5, 59, 2, 0});

    // Reset values
    repeat (2) @(negedge clk);
    chk24("reset", 12, 0, 0, 0);
    check("reset.pm24", 32'(pm24), 0);
    chk12("reset", 11, 59, 0, 0, 0);
    rst_n = 1'b1;

    // Table: first row is the first strobe after reset release
    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].mode, vq[i].dn, vq[i].hz, vq[i].ts);
      chk24($sformatf("vec%0d", i), vq[i].h, vq[i].m, vq[i].s, vq[i].day);
    end

    // 12h: 11:59:59 AM -> 12:00:00 PM, then 11:59:59 PM -> 12:00:00 AM
    do_reset();
    repeat (59) tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    chk12("am_1159", 11, 59, 59, 0, 0);
    tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    chk12("noon", 12, 0, 0, 1, 0);
    chk24("min_carry24", 12, 1, 0, 0);
    repeat (11) tick(MODE_SET_HOUR, 1'b0, 1'b0, 1'b1);
    chk12("set_11pm", 11, 0, 0, 1, 0);
    tick(MODE_SET_MIN, 1'b1, 1'b0, 1'b1);
    repeat (59) tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    chk12("pm_1159", 11, 59, 59, 1, 0);
    check("no_early_day12", 32'(day12_seen), 0);
    tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    chk12("midnight12", 12, 0, 0, 0, 1);
    day12_seen = 0;
    tick(MODE_COUNT, 1'b0, 1'b0, 1'b0);
    check("day12_one_cycle", 32'(day12), 0);
    tick(MODE_SET_HOUR, 1'b1, 1'b0, 1'b1);
    chk12("set_dn_12am", 11, 0, 0, 1, 0);
    tick(MODE_SET_HOUR, 1'b0, 1'b0, 1'b1);
    chk12("set_up_11pm", 12, 0, 0, 0, 0);
    tick(MODE_SET_HOUR, 1'b0, 1'b0, 1'b1);
    chk12("set_up_12", 1, 0, 0, 0, 0);
    tick(MODE_SET_HOUR, 1'b1, 1'b0, 1'b1);
    chk12("set_dn_1", 12, 0, 0, 0, 0);
    check("no_set_day12", 32'(day12_seen), 0);

    // 24h: 23:59:59 -> 00:00:00 with a single-cycle day pulse
    do_reset();
    repeat (11) tick(MODE_SET_HOUR, 1'b0, 1'b0, 1'b1);
    tick(MODE_SET_MIN, 1'b1, 1'b0, 1'b1);
    repeat (59) tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    chk24("pre_midnight", 23, 59, 59, 0);
    check("no_early_day24", 32'(day24_seen), 0);
    tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    chk24("midnight24", 0, 0, 0, 1);
    day24_seen = 0;
    tick(MODE_COUNT, 1'b0, 1'b0, 1'b0);
    check("day24_one_cycle", 32'(day24), 0);
    tick(MODE_SET_HOUR, 1'b1, 1'b0, 1'b1);
    chk24("set_dn_0", 23, 0, 0, 0);
    tick(MODE_SET_HOUR, 1'b0, 1'b0, 1'b1);
    chk24("set_up_23", 0, 0, 0, 0);
    check("no_set_day24", 32'(day24_seen), 0);
    check("pm24_const", 32'(pm24), 0);

    // Strobe select, CLEAR_SEC, asynchronous reset mid-count
    do_reset();
    repeat (42) tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    chk24("sec42", 12, 0, 42, 0);
    mode = MODE_CLEAR_SEC; stb_ts = 1'b1; stb_1hz = 1'b0;
    #1 check("clk_stb_ts", 32'(cs24), 1);
    stb_ts = 1'b0; stb_1hz = 1'b1;
    #1 check("clk_stb_ts_only", 32'(cs24), 0);
    mode = MODE_COUNT;
    #1 check("clk_stb_1hz", 32'(cs24), 1);
    stb_1hz = 1'b0;
    tick(MODE_CLEAR_SEC, 1'b0, 1'b0, 1'b1);
    chk24("clear_sec", 12, 0, 0, 0);
    repeat (3) tick(MODE_SET_MIN, 1'b0, 1'b0, 1'b1);
    tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    chk24("pre_async", 12, 3, 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk24("async_rst", 12, 0, 0, 0);
    chk12("async_rst", 11, 59, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ADV_CLOCK_ALARM_EN
    do_reset();
    check("alarm_rst_h24", 32'(ah24), 0);
    check("alarm_rst_m24", 32'(am24), 0);
    check("alarm_rst_h12", 32'(ah12), 12);
    check("alarm_rst_pm12", 32'(apm12), 0);
    alarm_sel = 1'b1;
    repeat (6) tick(MODE_SET_HOUR, 1'b0, 1'b0, 1'b1);
    repeat (30) tick(MODE_SET_MIN, 1'b0, 1'b0, 1'b1);
    check("alarm_set_h", 32'(ah24), 6);
    check("alarm_set_m", 32'(am24), 30);
    chk24("alarm_time_held", 12, 0, 0, 0);
    alarm_sel = 1'b0;
    repeat (6) tick(MODE_SET_HOUR, 1'b1, 1'b0, 1'b1);
    repeat (29) tick(MODE_SET_MIN, 1'b0, 1'b0, 1'b1);
    alarm_en = 1'b1;
    repeat (59) tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    chk24("alarm_pre", 6, 29, 59, 0);
    check("alarm_none_early", 32'(alarm_cnt), 0);
    tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    check("alarm_hit", 32'(al24), 1);
    tick(MODE_COUNT, 1'b0, 1'b0, 1'b0);
    check("alarm_one_cycle", 32'(al24), 0);
    tick(MODE_SET_MIN, 1'b1, 1'b0, 1'b1);
    alarm_en = 1'b0;
    repeat (60) tick(MODE_COUNT, 1'b0, 1'b1, 1'b0);
    chk24("alarm_dis_time", 6, 30, 0, 0);
    check("alarm_disabled", 32'(alarm_cnt), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
